aes_inv_cipher_iter: RTL and testbench
======================================

// Module: aes_inv_cipher_iter
// PURPOSE
//  Iterative AES inverse cipher: one ciphertext block in, one plaintext block out, one round per clock.
//  Each round applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
//  Round keys come from an external key-schedule store through a zero-latency index/data lookup.
//  Sits on the decrypt path as the counterpart of the forward round datapath. Uses the same row-major state bus.
// PARAMETERS
//  NR  10  number of rounds (10/12/14 = AES-128/192/256); key store must hold NR+1 round keys
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       ciphertext offered
//  in_ready   out  1       block can accept ciphertext
//  in_data    in   [0:127] ciphertext, state layout
//  rk_idx     out  [3:0]   round-key index requested this cycle
//  rk         in   [0:127] round key for rk_idx, valid same cycle (combinational), state layout
//  out_valid  out  1       plaintext available
//  out_ready  in   1       consumer takes plaintext
//  out_data   out  [0:127] plaintext, state layout
//  busy       out  1       high in ROUND/FINAL
// BEHAVIOUR
//  State layout: byte b = bits [8b:8b+7]; b = 4*row + col (row-major).
//   FIPS-197 byte k maps to b = 4*(k%4) + k/4.
//  InvShiftRows: new[4r+c] = old[4r + ((c-r) mod 4)]; row0 unchanged; row1 new[4]=old[7], new[5]=old[4].
//  InvMixColumns: column c = bytes {c, 4+c, 8+c, 12+c}; matrix rows {0e,0b,0d,09} rotated; GF(2^8) poly 0x11b.
//  InvSubBytes: FIPS-197 inverse S-box, combinational, 16 instances.
//  FSM states and transitions:
//   IDLE  -> ROUND  on in_valid && in_ready; st <= in_data ^ rk (rk_idx = NR); rnd <= NR-1
//   ROUND -> ROUND  st <= InvMixCol(InvSub(InvShift(st)) ^ rk), rk_idx = rnd; rnd-- ; leave when rnd == 1
//   ROUND -> FINAL  after the rnd == 1 round
//   FINAL -> DONE   out_data <= InvSub(InvShift(st)) ^ rk, rk_idx = 0; out_valid <= 1
//   DONE  -> IDLE   on out_ready; out_valid <= 0
//  Outputs per state:
//   in_ready = (state == IDLE); in_valid outside IDLE is ignored, not queued.
//   rk_idx = NR in IDLE and DONE, rnd in ROUND, 0 in FINAL.
//  Latency: accept edge E0; ROUND edges E1..E(NR-1); FINAL edge E(NR).
//   out_valid is high from E(NR) (10 cycles for NR=10).
//  Throughput: next accept no earlier than the cycle after the output handshake (min NR+2 cycles/block).
//  DONE with out_ready low: out_valid and out_data held stable indefinitely; in_ready stays 0.
//  out_data keeps its last value after handshake until the next FINAL edge.
//  Reset values: state IDLE, out_valid 0, in_ready 1 (first cycle after reset), busy 0,
//   rk_idx NR, out_data 0, st 0, rnd 0.
//  Reset mid-operation (any state): in-flight block discarded; out_valid never asserts for it; IDLE next cycle.
//  rst has priority over every handshake in the same cycle.
//  NR outside {10,12,14}: elaboration error.
// TESTING
//  FIPS-197 C.1, NR=10, key-store loaded with the expansion of key 000102..0f:
//   in_data = 69c4e0d86a7b0430d8cdb78070b4c55a (FIPS order)
//   -> out_data = 00112233445566778899aabbccddeeff, out_valid 10 cycles after accept.
//  FIPS-197 C.3, NR=14, key 000102..1f:
//   in 8ea2b7ca516745bfeafc49904b496089 -> out 00112233..eeff, latency 14.
//  rk_idx trace for NR=10 from accept cycle: 10,9,8,...,1,0, then 10 in DONE.
//   No other index values appear.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0.
//   Pulsing in_valid meanwhile is ignored; one output handshake only.
//  Reset at cycle 5 after accept -> out_valid stays 0, in_ready=1 next cycle.
//   A new block is then accepted and decrypted correctly.
//  Two back-to-back blocks (C.1 ct, then its ct with byte 0 flipped), out_ready tied 1:
//   -> two correct outputs, second accept exactly 1 cycle after first output handshake.

Source files
------------

// File: rtl/aes_inv_cipher_iter_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter_if
//   Bundles the block-level handshakes and the round-key lookup of the
//   iterative AES inverse cipher.
//
//   in_valid / in_ready / in_data    ciphertext in (state layout, [0:127])
//   rk_idx / rk                      round-key index out, round key back in
//                                    the same cycle (combinational store)
//   out_valid / out_ready / out_data plaintext out (state layout)
//   busy                             a block is being decrypted
//
//   master: the side that offers ciphertext, owns the key store and
//           consumes plaintext.
//   slave : the cipher core.
// ---------------------------------------------------------------------------
interface aes_inv_cipher_iter_if;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   in_data;
    logic [3:0]     rk_idx;
    logic [0:127]   rk;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   out_data;
    logic           busy;

    modport master (
        output in_valid, in_data, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
//   Iterative AES inverse cipher, one round per clock. A ciphertext block is
//   whitened with round key NR on acceptance, then NR-1 full inverse rounds
//   (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) run with keys
//   NR-1..1, and a final round without InvMixColumns uses key 0.
//
//   Ports
//     clk   clock, all state changes on the rising edge
//     rst   synchronous reset, active high, overrides every handshake
//     bus   aes_inv_cipher_iter_if.slave: ciphertext in, round-key lookup,
//           plaintext out, busy
//
//   State layout: byte b occupies bits [8b:8b+7], b = 4*row + col.
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_inv_cipher_iter_if.slave    bus
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_IDX = 4'(NR);

    // -----------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11b
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e are all we need).
    function automatic logic [7:0] gmul_k(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Inverse S-box table built at elaboration: walk the powers of the
    // generator 3 to get multiplicative inverses, apply the forward affine
    // map, then store each input at the position of its S-box output.
    function automatic logic [2047:0] build_inv_sbox();
        logic [2047:0] exp_t;
        logic [2047:0] inv_t;
        logic [2047:0] tbl;
        logic [7:0]    p;
        logic [7:0]    b;
        logic [7:0]    s;
        int            e;
        exp_t = '0;
        inv_t = '0;
        tbl   = '0;
        p     = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[8*i +: 8] = p;
            p = p ^ xt(p);
        end
        for (int i = 0; i < 255; i++) begin
            e = int'(exp_t[8*i +: 8]);
            inv_t[8*e +: 8] = exp_t[8*((255 - i) % 255) +: 8];
        end
        for (int x = 0; x < 256; x++) begin
            b = inv_t[8*x +: 8];
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                {b[3:0], b[7:4]} ^ 8'h63;
            tbl[{s, 3'b000} +: 8] = 8'(x);
        end
        return tbl;
    endfunction

    localparam logic [2047:0] INV_SBOX_TBL = build_inv_sbox();

    function automatic logic [7:0] inv_sbox(input logic [7:0] v);
        return INV_SBOX_TBL[{v, 3'b000} +: 8];
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [0:127]   st_q, st_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [0:127]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     rk_idx;

    // -----------------------------------------------------------------------
    // Round datapath: shift -> sub -> add key -> mix. The final round taps
    // the add-key result and skips the mix.
    // -----------------------------------------------------------------------
    logic [0:127]   shifted;
    logic [0:127]   subbed;
    logic [0:127]   ark;
    logic [0:127]   mixed;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi / 4;
            localparam int COL = gi % 4;
            // Row r rotates right by r: new[r][c] takes old[r][(c-r) mod 4].
            localparam int SRC = 4*ROW + ((COL - ROW + 4) % 4);
            assign shifted[8*gi +: 8] = st_q[8*SRC +: 8];
            assign subbed[8*gi +: 8]  = inv_sbox(shifted[8*gi +: 8]);
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[8*gi +: 8];
            assign a1 = ark[8*(4 + gi) +: 8];
            assign a2 = ark[8*(8 + gi) +: 8];
            assign a3 = ark[8*(12 + gi) +: 8];
            assign mixed[8*gi +: 8]        = gmul_k(a0, 4'he) ^ gmul_k(a1, 4'hb) ^
                                             gmul_k(a2, 4'hd) ^ gmul_k(a3, 4'h9);
            assign mixed[8*(4 + gi) +: 8]  = gmul_k(a0, 4'h9) ^ gmul_k(a1, 4'he) ^
                                             gmul_k(a2, 4'hb) ^ gmul_k(a3, 4'hd);
            assign mixed[8*(8 + gi) +: 8]  = gmul_k(a0, 4'hd) ^ gmul_k(a1, 4'h9) ^
                                             gmul_k(a2, 4'he) ^ gmul_k(a3, 4'hb);
            assign mixed[8*(12 + gi) +: 8] = gmul_k(a0, 4'hb) ^ gmul_k(a1, 4'hd) ^
                                             gmul_k(a2, 4'h9) ^ gmul_k(a3, 4'he);
        end
    endgenerate

    assign ark = subbed ^ bus.rk;

    // -----------------------------------------------------------------------
    // FSM: next state, datapath selects and key index
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rk_idx      = NR_IDX;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.rk;
                    rnd_d   = NR_IDX - 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                rk_idx = rnd_q;
                st_d   = mixed;
                rnd_d  = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                rk_idx      = 4'd0;
                out_data_d  = ark;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.rk_idx    = rk_idx;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == S_ROUND) || (state_q == S_FINAL);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
//   Two cipher instances (NR=10 with the FIPS-197 C.1 key, NR=14 with the
//   C.3 key). A FIPS-order AES InvCipher model predicts every plaintext;
//   a cycle-age model predicts the handshake and key-index outputs.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst;

    aes_inv_cipher_iter_if bus10 ();
    aes_inv_cipher_iter_if bus14 ();

    aes_inv_cipher_iter #(.NR(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
    aes_inv_cipher_iter #(.NR(14)) dut14 (.clk(clk), .rst(rst), .bus(bus14));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [0:127] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [0:127] rkf [2][16];   // round keys, FIPS byte order
    logic [0:127] ks  [2][16];   // round keys, state layout (key store)
    int           nr_of [2] = '{10, 14};

    // behavioural model state per lane
    int           age     [2];
    logic [0:127] pend    [2];
    logic [0:127] exp_out [2];
    int           dut_hs  [2];
    bit           chk_en = 1'b0;

    assign bus10.rk = ks[0][bus10.rk_idx];
    assign bus14.rk = ks[1][bus14.rk_idx];

    // ------------------------------------------------------------------ math
    function automatic logic [7:0] xtime8(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xtime8(a);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                    {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    function automatic logic [0:127] transpose(input logic [0:127] v);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) r[8*(4*(k%4) + k/4) +: 8] = v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand_key(input int ln, input logic [0:255] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime8(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rkf[ln][r] = '0;
            ks[ln][r]  = '0;
        end
        for (int r = 0; r <= nr; r++) begin
            rkf[ln][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            ks[ln][r]  = transpose(rkf[ln][r]);
        end
    endtask

    // FIPS-197 InvCipher on a FIPS-ordered block (byte k = state[k%4][k/4]).
    function automatic logic [0:127] model_decrypt(input int ln, input logic [0:127] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a [4];
        logic [0:127] res;
        int           nr;
        nr = nr_of[ln];
        for (int k = 0; k < 16; k++) s[k%4][k/4] = ct[8*k +: 8] ^ rkf[ln][nr][8*k +: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 4; c++) t[i][(c+i)%4] = isb[s[i][c]];
            for (int k = 0; k < 16; k++) s[k%4][k/4] = t[k%4][k/4] ^ rkf[ln][r][8*k +: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[i][c];
                    s[0][c] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
                    s[1][c] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
                    s[2][c] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
                    s[3][c] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
                end
            end
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k%4][k/4];
        return res;
    endfunction

    // ------------------------------------------------------------- checking
    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_lane(input int ln, input logic ir, input logic [3:0] idx,
                              input logic ov, input logic [0:127] od, input logic bz,
                              input logic iv, input logic [0:127] id, input logic ordy);
        int         nr;
        logic [3:0] e_idx;
        logic       inflight;
        nr       = nr_of[ln];
        inflight = (age[ln] >= 1) && (age[ln] <= nr);
        e_idx    = inflight ? 4'(nr - age[ln]) : 4'(nr);
        cmp($sformatf("lane%0d in_ready", ln),  128'(ir),  128'(age[ln] == 0));
        cmp($sformatf("lane%0d busy", ln),      128'(bz),  128'(inflight));
        cmp($sformatf("lane%0d out_valid", ln), 128'(ov),  128'(age[ln] == nr + 1));
        cmp($sformatf("lane%0d rk_idx", ln),    128'(idx), 128'(e_idx));
        cmp($sformatf("lane%0d out_data", ln),  od,        exp_out[ln]);
        if (ov && ordy) dut_hs[ln]++;
        // predict the effect of the coming rising edge
        if (rst) begin
            age[ln]     = 0;
            exp_out[ln] = '0;
        end else if (age[ln] == 0) begin
            if (iv) begin
                age[ln]  = 1;
                pend[ln] = transpose(model_decrypt(ln, transpose(id)));
            end
        end else if (age[ln] <= nr) begin
            age[ln]++;
            if (age[ln] == nr + 1) exp_out[ln] = pend[ln];
        end else if (ordy) begin
            age[ln] = 0;
            $display("tx lane %0d nr %0d pt %h", ln, nr, transpose(exp_out[ln]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_lane(0, bus10.in_ready, bus10.rk_idx, bus10.out_valid, bus10.out_data,
                       bus10.busy, bus10.in_valid, bus10.in_data, bus10.out_ready);
            check_lane(1, bus14.in_ready, bus14.rk_idx, bus14.out_valid, bus14.out_data,
                       bus14.busy, bus14.in_valid, bus14.in_data, bus14.out_ready);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic lane_out_valid(input int ln);
        return (ln == 0) ? bus10.out_valid : bus14.out_valid;
    endfunction

    task automatic wait_valid(input int ln, input int budget, output int n);
        n = 0;
        while (!lane_out_valid(ln) && n < budget) begin
            tick();
            n++;
        end
        if (!lane_out_valid(ln)) begin
            checks++;
            errors++;
            $display("FAIL lane%0d out_valid timeout actual none after %0d cycles required within %0d",
                     ln, n, budget);
        end
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int           n;
        int           hs0;
        logic [0:127] b_ct;

        for (int i = 0; i < 2; i++) begin
            age[i]     = 0;
            pend[i]    = '0;
            exp_out[i] = '0;
            dut_hs[i]  = 0;
        end
        rst             = 1'b1;
        bus10.in_valid  = 1'b0;
        bus10.in_data   = '0;
        bus10.out_ready = 1'b0;
        bus14.in_valid  = 1'b0;
        bus14.in_data   = '0;
        bus14.out_ready = 1'b1;

        build_sbox();
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

        // pin the model itself
        cmp("model isb[00]", 128'(isb[0]), 128'(8'h52));
        cmp("model isb[63]", 128'(isb[8'h63]), 128'(8'h00));
        cmp("model c1 rk10", rkf[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        cmp("model c1 decrypt", model_decrypt(0, C1_CT), PT);
        cmp("model c3 decrypt", model_decrypt(1, C3_CT), PT);

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // C.1 with 5 cycles of backpressure and ignored in_valid pulses
        bus10.out_ready = 1'b0;
        bus10.in_data   = transpose(C1_CT);
        bus10.in_valid  = 1'b1;
        tick();
        bus10.in_valid  = 1'b0;
        wait_valid(0, 40, n);
        cmp("c1 latency", 128'(n), 128'(10));
        cmp("c1 out_data", bus10.out_data, transpose(PT));
        hs0 = dut_hs[0];
        repeat (5) begin
            bus10.in_valid = ($urandom_range(0, 1) == 1);
            bus10.in_data  = rnd128();
            tick();
            cmp("bp out_valid", 128'(bus10.out_valid), 128'(1));
            cmp("bp in_ready", 128'(bus10.in_ready), 128'(0));
            cmp("bp out_data", bus10.out_data, transpose(PT));
        end
        bus10.in_valid  = 1'b0;
        bus10.out_ready = 1'b1;
        tick();
        bus10.out_ready = 1'b0;
        tick();
        tick();
        cmp("bp handshakes", 128'(dut_hs[0] - hs0), 128'(1));

        // reset five cycles after accept, then a clean C.1 block
        bus10.out_ready = 1'b1;
        bus10.in_data   = rnd128();
        bus10.in_valid  = 1'b1;
        tick();
        bus10.in_valid  = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst out_valid", 128'(bus10.out_valid), 128'(0));
        cmp("rst in_ready", 128'(bus10.in_ready), 128'(1));
        repeat (12) tick();
        bus10.in_data  = transpose(C1_CT);
        bus10.in_valid = 1'b1;
        tick();
        bus10.in_valid = 1'b0;
        wait_valid(0, 40, n);
        cmp("post-rst latency", 128'(n), 128'(10));
        cmp("post-rst out_data", bus10.out_data, transpose(PT));
        tick();

        // back-to-back: C.1 then C.1 with FIPS byte 0 flipped
        b_ct       = C1_CT;
        b_ct[0:7]  = b_ct[0:7] ^ 8'hff;
        bus10.in_data  = transpose(C1_CT);
        bus10.in_valid = 1'b1;
        tick();
        bus10.in_data  = transpose(b_ct);
        wait_valid(0, 40, n);
        cmp("b2b first latency", 128'(n), 128'(10));
        cmp("b2b first out_data", bus10.out_data, transpose(PT));
        tick();
        cmp("b2b in_ready after handshake", 128'(bus10.in_ready), 128'(1));
        tick();
        cmp("b2b second accepted", 128'(bus10.busy), 128'(1));
        bus10.in_valid = 1'b0;
        wait_valid(0, 40, n);
        cmp("b2b second latency", 128'(n), 128'(10));
        tick();

        // C.3 on the NR=14 instance
        bus14.in_data  = transpose(C3_CT);
        bus14.in_valid = 1'b1;
        tick();
        bus14.in_valid = 1'b0;
        wait_valid(1, 40, n);
        cmp("c3 latency", 128'(n), 128'(14));
        cmp("c3 out_data", bus14.out_data, transpose(PT));
        tick();

        // randomized traffic on both lanes, rare resets
        repeat (800) begin
            bus10.in_valid  = ($urandom_range(0, 2) == 0);
            bus10.in_data   = rnd128();
            bus10.out_ready = ($urandom_range(0, 3) != 0);
            bus14.in_valid  = ($urandom_range(0, 2) == 0);
            bus14.in_data   = rnd128();
            bus14.out_ready = ($urandom_range(0, 3) != 0);
            rst             = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst             = 1'b0;
        bus10.in_valid  = 1'b0;
        bus10.out_ready = 1'b1;
        bus14.in_valid  = 1'b0;
        bus14.out_ready = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
